// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: 4-state command controller driving an external ALU over a small register file; define SEQ_CARRY_EN to chain carries through flag_c.
module alu_cmd_sequencer #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [2:0]            i_cmd_opc,
    input  logic [REG_ADDR_W-1:0] i_cmd_rd,
    input  logic [REG_ADDR_W-1:0] i_cmd_rs,
    input  logic                  i_ld_en,
    input  logic [REG_ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0]     i_ld_data,
    input  logic [REG_ADDR_W-1:0] i_rdbk_addr,
    output logic [DATA_W-1:0]     o_rdbk_data,
    output logic [DATA_W-1:0]     o_alu_inA,
    output logic [DATA_W-1:0]     o_alu_inB,
    output logic                  o_alu_inC,
    output logic [2:0]            o_alu_opc,
    input  logic [DATA_W-1:0]     i_alu_outW,
    input  logic                  i_alu_zer,
    input  logic                  i_alu_neg,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_flag_z,
    output logic                  o_flag_n,
    output logic                  o_flag_c
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_ILL = 3'b111;
    logic [1:0]            r_state;
    logic [DATA_W-1:0]     r_regs [2**REG_ADDR_W];
    logic [2:0]            r_opc;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [DATA_W-1:0]     r_op_a;
    logic [DATA_W-1:0]     r_op_b;
    logic [DATA_W-1:0]     r_res;
    logic                  r_z;
    logic                  r_n;
    logic                  r_flag_z;
    logic                  r_flag_n;
    logic                  r_done;
    logic                  r_err;
    logic                  w_exec;
    logic                  w_accept;
    logic                  w_legal;
    assign w_exec      = r_state == S_EXEC;
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_legal     = r_opc != OPC_ILL;
    assign o_cmd_ready = r_state == S_IDLE;
    assign o_busy      = !o_cmd_ready;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_flag_z    = r_flag_z;
    assign o_flag_n    = r_flag_n;
    assign o_rdbk_data = r_regs[i_rdbk_addr];
    assign o_alu_inA   = w_exec ? r_op_a : '0;
    assign o_alu_inB   = w_exec ? r_op_b : '0;
    assign o_alu_opc   = w_exec ? r_opc : OPC_ILL;
`ifdef SEQ_CARRY_EN
    logic              r_c;
    logic              r_flag_c;
    logic [DATA_W:0]   w_sum;
    assign o_alu_inC = w_exec && r_opc == OPC_ADD && r_flag_c;
    assign w_sum     = {1'b0, r_op_a} + {1'b0, r_op_b} + {{DATA_W{1'b0}}, o_alu_inC};
    assign o_flag_c  = r_flag_c;
    // carry is recomputed locally because the ALU exposes no carry-out
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_c      <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            if (w_exec) r_c <= w_sum[DATA_W];
            if (r_state == S_WB && r_opc == OPC_ADD) r_flag_c <= r_c;
        end
    end
`else
    assign o_alu_inC = 1'b0;
    assign o_flag_c  = 1'b0;
`endif
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            for (int i = 0; i < 2**REG_ADDR_W; i++) r_regs[i] <= '0;
            r_opc    <= '0;
            r_rd     <= '0;
            r_rs     <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_res    <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_ld_en) r_regs[i_ld_addr] <= i_ld_data;
                    if (w_accept) begin
                        r_opc   <= i_cmd_opc;
                        r_rd    <= i_cmd_rd;
                        r_rs    <= i_cmd_rs;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_op_a  <= r_regs[r_rd];
                    r_op_b  <= r_regs[r_rs];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_res   <= i_alu_outW;
                    r_z     <= i_alu_zer;
                    r_n     <= i_alu_neg;
                    r_state <= S_WB;
                end
                default: begin
                    if (w_legal) begin
                        r_regs[r_rd] <= r_res;
                        r_flag_z     <= r_z;
                        r_flag_n     <= r_n;
                    end
                    r_done  <= 1'b1;
                    r_err   <= !w_legal;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench with a behavioural ALU and an arithmetic reference model of the register file and flags.
module tb_alu_cmd_sequencer;
`ifdef SEQ_CARRY_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif
    typedef struct {
        int          rd;
        logic [15:0] v;
        logic        z;
        logic        n;
        logic        c;
        logic        e;
        int          acc;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_opc = '0;
    logic [1:0]  cmd_rd = '0;
    logic [1:0]  cmd_rs = '0;
    logic        ld_en = 1'b0;
    logic [1:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [1:0]  rdbk_addr = '0;
    logic [15:0] rdbk_data;
    logic [15:0] alu_inA;
    logic [15:0] alu_inB;
    logic        alu_inC;
    logic [2:0]  alu_opc;
    logic [15:0] alu_outW;
    logic        alu_zer;
    logic        alu_neg;
    logic        busy;
    logic        done;
    logic        err;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_acc = -100;
    int          m [4];
    bit          m_z;
    bit          m_n;
    bit          m_c;
    exp_t        q [$];
    alu_cmd_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_opc(cmd_opc), .i_cmd_rd(cmd_rd), .i_cmd_rs(cmd_rs),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
        .i_rdbk_addr(rdbk_addr), .o_rdbk_data(rdbk_data),
        .o_alu_inA(alu_inA), .o_alu_inB(alu_inB), .o_alu_inC(alu_inC), .o_alu_opc(alu_opc),
        .i_alu_outW(alu_outW), .i_alu_zer(alu_zer), .i_alu_neg(alu_neg),
        .o_busy(busy), .o_done(done), .o_err(err),
        .o_flag_z(flag_z), .o_flag_n(flag_n), .o_flag_c(flag_c)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [15:0] alu_f(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input logic c);
        case (o)
            3'b000:  return ~a + 16'd1;
            3'b001:  return a - b;
            3'b010:  return a + b + {15'd0, c};
            3'b011:  return a & b;
            3'b100:  return a | b;
            3'b101:  return a ^ b;
            3'b110:  return {a[15:8], b[7:0]};
            default: return 16'd0;
        endcase
    endfunction
    assign alu_outW = alu_f(alu_opc, alu_inA, alu_inB, alu_inC);
    assign alu_zer  = alu_outW == 16'd0;
    assign alu_neg  = alu_outW[15];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = 0;
        m_z = 0;
        m_n = 0;
        m_c = 0;
    endtask
    task automatic model_cmd(input logic [2:0] o, input int rd, input int rs, input int acc);
        int a, b, s, r, cin;
        bit cout;
        a = m[rd];
        b = m[rs];
        cin = (CE && o == 3'd2) ? int'(m_c) : 0;
        cout = 0;
        r = a;
        case (o)
            3'd0: r = (65536 - a) % 65536;
            3'd1: r = (a - b + 65536) % 65536;
            3'd2: begin s = a + b + cin; r = s % 65536; cout = s > 65535; end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = (a / 256) * 256 + b % 256;
            default: r = a;
        endcase
        if (o != 3'd7) begin
            m[rd] = r;
            m_z = r == 0;
            m_n = r >= 32768;
            if (o == 3'd2 && CE) m_c = cout;
        end
        q.push_back('{rd, 16'(m[rd]), m_z, m_n, m_c, o == 3'd7, acc});
    endtask
    task automatic wait_ready();
        int n = 0;
        #1;
        while (!cmd_ready && n < 16) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 1);
    endtask
    task automatic ld(input int a, input logic [15:0] d);
        @(negedge clk);
        wait_ready();
        ld_en = 1'b1;
        ld_addr = 2'(a);
        ld_data = d;
        m[a] = int'(d);
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask
    task automatic ld_busy(input int a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1;
        ld_addr = 2'(a);
        ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask
    task automatic issue(input logic [2:0] o, input int rd, input int rs, input bit keep, input bit b2b,
                         input bit ldp, input int la, input logic [15:0] ldd);
        int acc;
        @(negedge clk);
        cmd_opc = o;
        cmd_rd = 2'(rd);
        cmd_rs = 2'(rs);
        cmd_valid = 1'b1;
        ld_en = ldp;
        ld_addr = 2'(la);
        ld_data = ldd;
        wait_ready();
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            ld_en = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (b2b) chk("accept_spacing", 32'(acc - last_acc), 4);
        last_acc = acc;
        if (ldp) m[la] = int'(ldd);
        model_cmd(o, rd, rs, acc);
        @(posedge clk);
        #1 ld_en = 1'b0;
        if (!keep) cmd_valid = 1'b0;
    endtask
    task automatic check_idle_state();
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_flags", {29'd0, flag_z, flag_n, flag_c}, 0);
    endtask
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) q.delete();
        else begin
            if (!busy) begin
                chk("alu_idle_opc", 32'(alu_opc), 7);
                chk("alu_idle_ab", {alu_inA, alu_inB}, 0);
                chk("alu_idle_c", 32'(alu_inC), 0);
            end
            if (done) begin
                if (q.size() == 0) chk("spurious_done", 32'(done), 0);
                else begin
                    e = q.pop_front();
                    rdbk_addr = 2'(e.rd);
                    #1;
                    chk("latency", 32'(cyc - e.acc), 3);
                    chk("err", 32'(err), 32'(e.e));
                    chk("reg_value", 32'(rdbk_data), 32'(e.v));
                    chk("flag_z", 32'(flag_z), 32'(e.z));
                    chk("flag_n", 32'(flag_n), 32'(e.n));
                    chk("flag_c", 32'(flag_c), 32'(e.c));
                end
            end else if (q.size() > 0 && cyc > q[0].acc + 3) begin
                chk("done_timeout", 32'(done), 1);
                void'(q.pop_front());
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end
    initial begin
        bit cur, nb, ldp;
        logic [15:0] d;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check_idle_state();
        for (int i = 0; i < 4; i++) issue(3'b011, i, i, 0, 0, 0, 0, 16'h0);
        ld(0, 16'h0005);
        ld(1, 16'h0003);
        issue(3'b010, 0, 1, 0, 0, 0, 0, 16'h0);
        ld(2, 16'hFFFF);
        ld(3, 16'h0001);
        issue(3'b010, 2, 3, 0, 0, 0, 0, 16'h0);
        ld(0, 16'h0000);
        ld(1, 16'h0000);
        issue(3'b010, 0, 1, 0, 0, 0, 0, 16'h0);
        ld(0, 16'h0001);
        issue(3'b000, 0, 0, 0, 0, 0, 0, 16'h0);
        ld(1, 16'h12AB);
        issue(3'b110, 0, 1, 0, 0, 0, 0, 16'h0);
        issue(3'b111, 1, 0, 0, 0, 0, 0, 16'h0);
        issue(3'b010, 1, 1, 0, 0, 1, 1, 16'h8101);
        // reset lands on the EXEC cycle of a subtract
        ld(0, 16'h1234);
        ld(1, 16'h0F0F);
        issue(3'b001, 0, 1, 0, 0, 0, 0, 16'h0);
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        model_reset();
        check_idle_state();
        repeat (4) begin
            @(negedge clk);
            #1 chk("no_done_after_rst", 32'(done), 0);
        end
        issue(3'b011, 0, 0, 0, 0, 0, 0, 16'h0);
        ld(3, 16'h00F0);
        issue(3'b011, 2, 2, 0, 0, 0, 0, 16'h0);
        ld_busy(3, 16'hBEEF);
        issue(3'b011, 3, 3, 0, 0, 0, 0, 16'h0);
        issue(3'b100, 0, 3, 1, 0, 0, 0, 16'h0);
        issue(3'b101, 1, 0, 1, 1, 0, 0, 16'h0);
        issue(3'b010, 0, 0, 1, 1, 0, 0, 16'h0);
        issue(3'b010, 2, 0, 0, 1, 0, 0, 16'h0);
        cur = 0;
        for (int it = 0; it < 200; it++) begin
            if (!cur && $urandom_range(2) == 0) begin
                d = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
                ld(int'($urandom_range(3)), d);
            end
            nb = (it < 199) && ($urandom_range(1) == 1);
            ldp = $urandom_range(3) == 0;
            d = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
            issue(($urandom_range(2) == 0) ? 3'b010 : 3'($urandom), int'($urandom_range(3)),
                  int'($urandom_range(3)), nb, cur, ldp, int'($urandom_range(3)), d);
            if (!nb) repeat ($urandom_range(2)) @(negedge clk);
            cur = nb;
        end
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) chk("drain", 32'(q.size()), 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
